// File: rtl/cell_write_ctrl.sv
// Ingress cell writer: packs a beat stream into fixed-size linked cells, writes them on
// memory port A and hands one {head, length} descriptor per frame to the queue manager.
module cell_write_ctrl #(
  parameter int  DATA_W     = 64,
  parameter int  CELL_BEATS = 7,
  parameter int  ADDR_W     = 10,
  parameter int  LEN_W      = 14,
  localparam int NB         = DATA_W / 8,
  localparam int PAYLOAD_W  = CELL_BEATS * DATA_W,
  localparam int BYTES_W    = $clog2(NB + 1),
  localparam int CNT_W      = $clog2(CELL_BEATS * NB + 1),
  localparam int FOOTER_W   = ADDR_W + CNT_W + 2,
  localparam int BLOCK_W    = PAYLOAD_W + FOOTER_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               data_valid_i,
  input  logic               data_begin_i,
  input  logic               data_end_i,
  input  logic [BYTES_W-1:0] data_bytes_i,
  output logic               data_ready_o,
  output logic               fl_alloc_req_o,
  input  logic               fl_alloc_gnt_i,
  input  logic [ADDR_W-1:0]  fl_alloc_idx_i,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_wdata_o,
  output logic               desc_valid_o,
  input  logic               desc_ready_i,
  output logic [ADDR_W-1:0]  desc_head_o,
  output logic [LEN_W-1:0]   desc_len_o,
  output logic               len_err_o
);

  localparam int BEAT_W = $clog2(CELL_BEATS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 active_q;
  logic                 curr_v_q, curr_v_d;
  logic [ADDR_W-1:0]    curr_idx_q, curr_idx_d;
  logic                 pf_v_q, pf_v_d;
  logic [ADDR_W-1:0]    pf_idx_q, pf_idx_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [CNT_W-1:0]     cell_bytes_q, cell_bytes_d;
  logic                 last_q, last_d;
  logic                 first_q, first_d;
  logic [ADDR_W-1:0]    head_q, head_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 sat_q, sat_d;

  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                 desc_valid_q, desc_valid_d;
  logic [ADDR_W-1:0]    desc_head_q, desc_head_d;
  logic [LEN_W-1:0]     desc_len_q, desc_len_d;
  logic                 len_err_q, len_err_d;

  logic                 accept;
  logic                 fire_mid, fire_last;
  logic [BYTES_W-1:0]   beat_bytes;
  logic [DATA_W-1:0]    beat_m;
  logic [LEN_W:0]       len_sum;

  // active_q keeps every output low while reset is asserted.
  assign data_ready_o   = active_q && (state_q == S_IDLE || state_q == S_FILL);
  assign fl_alloc_req_o = active_q && (!curr_v_q || !pf_v_q);
  assign accept         = data_valid_i && data_ready_o;

  assign fire_mid  = (state_q == S_PEND) && !last_q && curr_v_q && pf_v_q;
  assign fire_last = (state_q == S_PEND) && last_q && curr_v_q && !(desc_valid_q && !desc_ready_i);

  assign beat_bytes = data_end_i ? data_bytes_i : BYTES_W'(NB);
  assign len_sum    = {1'b0, len_q} + (LEN_W+1)'(beat_bytes);

  // The end beat is MSB-aligned: bytes below the valid count are zeroed.
  always_comb begin
    beat_m = '0;
    for (int b = 0; b < NB; b++) begin
      if (!data_end_i || b >= NB - int'(data_bytes_i)) beat_m[b*8 +: 8] = data_i[b*8 +: 8];
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold/default value first, so no path infers a latch.
    state_d      = state_q;
    curr_v_d     = curr_v_q;
    curr_idx_d   = curr_idx_q;
    pf_v_d       = pf_v_q;
    pf_idx_d     = pf_idx_q;
    beat_d       = beat_q;
    payload_d    = payload_q;
    cell_bytes_d = cell_bytes_q;
    last_d       = last_q;
    first_d      = first_q;
    head_d       = head_q;
    len_d        = len_q;
    sat_d        = sat_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    desc_valid_d = desc_valid_q && !desc_ready_i;
    desc_head_d  = desc_head_q;
    desc_len_d   = desc_len_q;
    len_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && data_begin_i) begin
          payload_d                          = '0;
          payload_d[PAYLOAD_W-1 -: DATA_W]   = beat_m;
          beat_d       = BEAT_W'(1);
          cell_bytes_d = CNT_W'(beat_bytes);
          len_d        = LEN_W'(beat_bytes);
          sat_d        = 1'b0;
          first_d      = 1'b1;
          last_d       = data_end_i;
          state_d      = (data_end_i || CELL_BEATS == 1) ? S_PEND : S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          payload_d[PAYLOAD_W-1-int'(beat_q)*DATA_W -: DATA_W] = beat_m;
          beat_d       = beat_q + 1'b1;
          cell_bytes_d = cell_bytes_q + CNT_W'(beat_bytes);
          if (sat_q || len_sum[LEN_W]) begin
            len_d = '1;
            sat_d = 1'b1;
          end else begin
            len_d = len_sum[LEN_W-1:0];
          end
          last_d = data_end_i;
          if (data_end_i || beat_q == BEAT_W'(CELL_BEATS-1)) state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (fire_mid || fire_last) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = curr_idx_q;
          payload_d    = '0;
          beat_d       = '0;
          cell_bytes_d = '0;
          first_d      = 1'b0;
          if (first_q) head_d = curr_idx_q;
        end
        if (fire_mid) begin
          mem_wdata_d = {payload_q, 1'b1, 1'b0, cell_bytes_q, pf_idx_q};
          state_d     = S_FILL;
        end
        if (fire_last) begin
          mem_wdata_d  = {payload_q, 1'b1, 1'b1, cell_bytes_q, {ADDR_W{1'b0}}};
          desc_valid_d = 1'b1;
          desc_head_d  = first_q ? curr_idx_q : head_q;
          desc_len_d   = len_q;
          len_err_d    = sat_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The prefetched block moves up first; a same-cycle grant then fills whichever slot is empty.
    if (fire_mid || fire_last) begin
      curr_v_d   = pf_v_q;
      curr_idx_d = pf_idx_q;
      pf_v_d     = 1'b0;
    end
    if (fl_alloc_req_o && fl_alloc_gnt_i) begin
      if (!curr_v_d) begin
        curr_v_d   = 1'b1;
        curr_idx_d = fl_alloc_idx_i;
      end else if (!pf_v_d) begin
        pf_v_d   = 1'b1;
        pf_idx_d = fl_alloc_idx_i;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      active_q     <= 1'b0;
      curr_v_q     <= 1'b0;
      curr_idx_q   <= '0;
      pf_v_q       <= 1'b0;
      pf_idx_q     <= '0;
      beat_q       <= '0;
      payload_q    <= '0;
      cell_bytes_q <= '0;
      last_q       <= 1'b0;
      first_q      <= 1'b0;
      head_q       <= '0;
      len_q        <= '0;
      sat_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      desc_valid_q <= 1'b0;
      desc_head_q  <= '0;
      desc_len_q   <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= 1'b1;
      curr_v_q     <= curr_v_d;
      curr_idx_q   <= curr_idx_d;
      pf_v_q       <= pf_v_d;
      pf_idx_q     <= pf_idx_d;
      beat_q       <= beat_d;
      payload_q    <= payload_d;
      cell_bytes_q <= cell_bytes_d;
      last_q       <= last_d;
      first_q      <= first_d;
      head_q       <= head_d;
      len_q        <= len_d;
      sat_q        <= sat_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      desc_valid_q <= desc_valid_d;
      desc_head_q  <= desc_head_d;
      desc_len_q   <= desc_len_d;
      len_err_q    <= len_err_d;
    end
  end

  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign desc_valid_o = desc_valid_q;
  assign desc_head_o  = desc_head_q;
  assign desc_len_o   = desc_len_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_cell_write_ctrl.sv
// Directed bench for cell_write_ctrl: a free list handing out indices 100, 101, ... and
// monitors logging every cell write and descriptor handshake.
module tb_cell_write_ctrl;

  localparam int DATA_W     = 64;
  localparam int CELL_BEATS = 7;
  localparam int ADDR_W     = 10;
  localparam int LEN_W      = 14;
  localparam int PAYLOAD_W  = CELL_BEATS * DATA_W;
  localparam int BYTES_W    = 4;
  localparam int CNT_W      = 6;
  localparam int BLOCK_W    = PAYLOAD_W + ADDR_W + CNT_W + 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [DATA_W-1:0]  data_i = '0;
  logic               data_valid_i = 1'b0;
  logic               data_begin_i = 1'b0;
  logic               data_end_i = 1'b0;
  logic [BYTES_W-1:0] data_bytes_i = '0;
  logic               data_ready_o;
  logic               fl_alloc_req_o;
  logic               fl_alloc_gnt_i;
  logic [ADDR_W-1:0]  fl_alloc_idx_i;
  logic               mem_we_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [BLOCK_W-1:0] mem_wdata_o;
  logic               desc_valid_o;
  logic               desc_ready_i = 1'b1;
  logic [ADDR_W-1:0]  desc_head_o;
  logic [LEN_W-1:0]   desc_len_o;
  logic               len_err_o;

  cell_write_ctrl #(
    .DATA_W(DATA_W), .CELL_BEATS(CELL_BEATS), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_begin_i(data_begin_i),
    .data_end_i(data_end_i), .data_bytes_i(data_bytes_i), .data_ready_o(data_ready_o),
    .fl_alloc_req_o(fl_alloc_req_o), .fl_alloc_gnt_i(fl_alloc_gnt_i), .fl_alloc_idx_i(fl_alloc_idx_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .desc_head_o(desc_head_o),
    .desc_len_o(desc_len_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  // Free list: grants immediately while enabled, indices count up from 100 after each reset.
  logic fl_en = 1'b1;
  int   fl_cnt;
  assign fl_alloc_gnt_i = fl_alloc_req_o && fl_en;
  assign fl_alloc_idx_i = ADDR_W'(100 + fl_cnt);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fl_cnt <= 0;
    else if (fl_alloc_gnt_i) fl_cnt <= fl_cnt + 1;
  end

  int                 wr_n = 0, desc_n = 0, rdy_low = 0, err_n = 0, err_desc_n = 0;
  logic [ADDR_W-1:0]  wr_addr [64];
  logic [BLOCK_W-1:0] wr_data [64];
  logic [ADDR_W-1:0]  dh [16];
  logic [LEN_W-1:0]   dl [16];

  always @(negedge clk) begin
    if (mem_we_o) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = mem_addr_o;
        wr_data[wr_n] = mem_wdata_o;
      end
      wr_n++;
    end
    if (desc_valid_o && desc_ready_i) begin
      if (desc_n < 16) begin
        dh[desc_n] = desc_head_o;
        dl[desc_n] = desc_len_o;
      end
      desc_n++;
    end
    if (!data_ready_o) rdy_low++;
    if (len_err_o) err_n++;
    if (len_err_o && desc_valid_o) err_desc_n++;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int f, input int k);
    logic [7:0] b;
    b = 8'(f * 16 + k + 1);
    return {8{b}};
  endfunction

  // Expected payload of a cell holding beats k0..k0+n-1 of frame f; lastb < 8 trims the final beat.
  function automatic logic [PAYLOAD_W-1:0] cell_pl(input int f, input int k0, input int n, input int lastb);
    logic [PAYLOAD_W-1:0] p;
    logic [DATA_W-1:0]    d;
    logic [DATA_W-1:0]    ones;
    p    = '0;
    ones = '1;
    for (int i = 0; i < n; i++) begin
      d = pat(f, k0 + i);
      if (i == n - 1 && lastb < 8) d = d & ~(ones >> (8 * lastb));
      p[PAYLOAD_W-1-i*DATA_W -: DATA_W] = d;
    end
    return p;
  endfunction

  function automatic logic [BLOCK_W-1:0] blk(input logic [PAYLOAD_W-1:0] pl, input logic eop,
                                              input int bytes, input int nxt);
    return {pl, 1'b1, eop, CNT_W'(bytes), ADDR_W'(nxt)};
  endfunction

  task automatic send(input logic [DATA_W-1:0] d, input logic b, input logic e, input int nb);
    int t;
    data_i       = d;
    data_valid_i = 1'b1;
    data_begin_i = b;
    data_end_i   = e;
    data_bytes_i = BYTES_W'(nb);
    t = 0;
    @(negedge clk);
    while (!data_ready_o && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) begin
      $display("FAIL send_timeout: data_ready_o stayed low for %0d cycles, required below 200", t);
      $fatal(1);
    end
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    data_begin_i = 1'b0;
    data_end_i   = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n, input int lastb);
    for (int k = 0; k < n; k++) send(pat(f, k), k == 0, k == n - 1, (k == n - 1) ? lastb : 8);
  endtask

  task automatic do_reset(input bit preload_pf);
    rst_n = 1'b0;
    data_valid_i = 1'b0;
    data_begin_i = 1'b0;
    data_end_i   = 1'b0;
    fl_en        = 1'b1;
    desc_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (!preload_pf) fl_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int w0, d0, r0, e0, k, hold_bad;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_ctrl", {data_ready_o, fl_alloc_req_o, mem_we_o, desc_valid_o, len_err_o}, '0);
    check("rst_bus", {mem_addr_o, desc_head_o, desc_len_o}, '0);
    check("rst_wdata", mem_wdata_o, '0);
    do_reset(1'b1);
    check("preload_grants", fl_cnt, 2);
    check("preload_req_low", fl_alloc_req_o, 1'b0);

    // 1: single full cell
    w0 = wr_n; d0 = desc_n; r0 = rdy_low;
    send_frame(0, 7, 8);
    repeat (5) @(posedge clk); #1;
    check("t1_nwr", wr_n - w0, 1);
    check("t1_addr", wr_addr[w0], 100);
    check("t1_wdata", wr_data[w0], blk(cell_pl(0, 0, 7, 8), 1'b1, 56, 0));
    check("t1_ndesc", desc_n - d0, 1);
    check("t1_desc", {dh[d0], dl[d0]}, {10'd100, 14'd56});
    check("t1_rdy_low", rdy_low - r0, 1);

    // 2: 15 beats, three chained cells, short end beat
    do_reset(1'b1);
    w0 = wr_n; d0 = desc_n;
    send_frame(1, 15, 3);
    repeat (5) @(posedge clk); #1;
    check("t2_nwr", wr_n - w0, 3);
    check("t2_addrs", {wr_addr[w0], wr_addr[w0+1], wr_addr[w0+2]}, {10'd100, 10'd101, 10'd102});
    check("t2_wd0", wr_data[w0],   blk(cell_pl(1, 0, 7, 8), 1'b0, 56, 101));
    check("t2_wd1", wr_data[w0+1], blk(cell_pl(1, 7, 7, 8), 1'b0, 56, 102));
    check("t2_wd2", wr_data[w0+2], blk(cell_pl(1, 14, 1, 3), 1'b1, 3, 0));
    check("t2_tail_bytes", wr_data[w0+2][BLOCK_W-1 -: 24], 24'h1F1F1F);
    check("t2_tail_zero", wr_data[w0+2][BLOCK_W-25:18], '0);
    check("t2_desc", {dh[d0], dl[d0]}, {10'd100, 14'd115});

    // 3: free list withholds the lookahead block, stall at the cell boundary
    do_reset(1'b0);
    check("t3_curr_only", fl_cnt, 1);
    w0 = wr_n; d0 = desc_n;
    for (int i = 0; i < 7; i++) send(pat(2, i), i == 0, 1'b0, 8);
    k = 0;
    repeat (5) begin
      @(negedge clk);
      if (data_ready_o) k++;
    end
    check("t3_stall_ready", k, 0);
    check("t3_stall_nowr", wr_n - w0, 0);
    @(posedge clk); #1 fl_en = 1'b1;
    @(posedge clk); #1;
    k = 0;
    @(negedge clk);
    while (!data_ready_o && k < 10) begin
      k++;
      @(negedge clk);
    end
    check("t3_resume", k, 1);
    send(pat(2, 7), 1'b0, 1'b1, 8);
    repeat (5) @(posedge clk); #1;
    check("t3_nwr", wr_n - w0, 2);
    check("t3_wd0", {wr_addr[w0], wr_data[w0]}, {10'd100, blk(cell_pl(2, 0, 7, 8), 1'b0, 56, 101)});
    check("t3_wd1", {wr_addr[w0+1], wr_data[w0+1]}, {10'd101, blk(cell_pl(2, 7, 1, 8), 1'b1, 8, 0)});
    check("t3_desc", {dh[d0], dl[d0]}, {10'd100, 14'd64});

    // 4: back-to-back frames, second starts on the carried-over block
    do_reset(1'b1);
    w0 = wr_n; d0 = desc_n;
    send_frame(3, 7, 8);
    send_frame(4, 7, 8);
    repeat (5) @(posedge clk); #1;
    check("t4_nwr", wr_n - w0, 2);
    check("t4_wd0", {wr_addr[w0], wr_data[w0]}, {10'd100, blk(cell_pl(3, 0, 7, 8), 1'b1, 56, 0)});
    check("t4_wd1", {wr_addr[w0+1], wr_data[w0+1]}, {10'd101, blk(cell_pl(4, 0, 7, 8), 1'b1, 56, 0)});
    check("t4_desc", {dh[d0], dl[d0], dh[d0+1], dl[d0+1]}, {10'd100, 14'd56, 10'd101, 14'd56});
    check("t4_grants", fl_cnt, 4);
    check("t4_req_idle", fl_alloc_req_o, 1'b0);

    // 5: descriptor back-pressure holds the second frame's last write
    do_reset(1'b1);
    desc_ready_i = 1'b0;
    w0 = wr_n; d0 = desc_n;
    send_frame(5, 7, 8);
    send_frame(6, 7, 8);
    hold_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!desc_valid_o || desc_head_o != 10'd100 || desc_len_o != 14'd56 || data_ready_o) hold_bad++;
    end
    check("t5_desc_hold", hold_bad, 0);
    check("t5_withheld", wr_n - w0, 1);
    @(posedge clk); #1 desc_ready_i = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("t5_nwr", wr_n - w0, 2);
    check("t5_wd1", {wr_addr[w0+1], wr_data[w0+1]}, {10'd101, blk(cell_pl(6, 0, 7, 8), 1'b1, 56, 0)});
    check("t5_desc", {dh[d0], dl[d0], dh[d0+1], dl[d0+1]}, {10'd100, 14'd56, 10'd101, 14'd56});
    check("t5_desc_drained", desc_valid_o, 1'b0);

    // 6: reset in the middle of a frame
    do_reset(1'b1);
    w0 = wr_n; d0 = desc_n;
    for (int i = 0; i < 3; i++) send(pat(7, i), i == 0, 1'b0, 8);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_ctrl", {data_ready_o, fl_alloc_req_o, mem_we_o, desc_valid_o, len_err_o}, '0);
    check("t6_rst_bus", {mem_addr_o, desc_head_o, desc_len_o}, '0);
    check("t6_rst_wdata", mem_wdata_o, '0);
    do_reset(1'b1);
    check("t6_nodesc", desc_n - d0, 0);
    send_frame(8, 7, 8);
    repeat (5) @(posedge clk); #1;
    check("t6_nwr", wr_n - w0, 1);
    check("t6_wd0", {wr_addr[w0], wr_data[w0]}, {10'd100, blk(cell_pl(8, 0, 7, 8), 1'b1, 56, 0)});
    check("t6_desc", {dh[d0], dl[d0]}, {10'd100, 14'd56});
    check("no_len_err_yet", err_n, 0);

    // 7: 2050 full beats = 16400 bytes saturates the 14-bit length
    do_reset(1'b1);
    w0 = wr_n; d0 = desc_n; e0 = err_desc_n;
    send_frame(9, 2050, 8);
    repeat (5) @(posedge clk); #1;
    check("t7_nwr", wr_n - w0, 293);
    check("t7_desc", {dh[d0], dl[d0]}, {10'd100, 14'd16383});
    check("t7_err_pulse", err_n, 1);
    check("t7_err_with_desc", err_desc_n - e0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
